float_unit_arbiter: RTL
=======================

FLOAT_UNIT_ARBITER -- requirements
Module: float_unit_arbiter

Interface
REQ-001 SHALL have parameter EXP, default 8: float exponent width.
REQ-002 SHALL have parameter FRAC, default 23: float fraction width; W = 1+EXP+FRAC (sign, exponent, fraction packed).
REQ-003 SHALL have parameter NUM_REQ, default 4: requester count, 2..16.
REQ-004 SHALL have parameter LAT, default 3: fixed latency of the shared float unit, 1..8 cycles.
REQ-005 SHALL have port clock  input  1  sole clock, rising edge.
REQ-006 SHALL have port resetn  input  1  synchronous, active-low reset.
REQ-007 SHALL have port req_valid  input  NUM_REQ  per-requester operation valid.
REQ-008 SHALL have port req_a  input  NUM_REQ*W  per-requester operand A, requester i in slice i.
REQ-009 SHALL have port req_b  input  NUM_REQ*W  per-requester operand B.
REQ-010 SHALL have port req_ready  output  NUM_REQ  one-hot grant; handshake = valid & ready.
REQ-011 SHALL have port unit_valid  output  1  issue strobe to the shared unit.
REQ-012 SHALL have port unit_a, unit_b  output  W each  issued operands.
REQ-013 SHALL have port unit_result  input  W  unit output, valid exactly LAT cycles after issue.
REQ-014 SHALL have port rsp_valid  output  NUM_REQ  one-hot result strobe to the owning requester.
REQ-015 SHALL have port rsp_data  output  W  result, shared by all requesters.
REQ-016 SHALL have port drain  input  1  level request to stop issuing.
REQ-017 SHALL have port idle  output  1  high when drained and nothing is in flight.

Function
REQ-018 SHALL grant at most one requester per cycle by round-robin: search starts at (last granted index + 1) mod NUM_REQ.
REQ-019 SHALL compute req_ready combinationally from req_valid and the current priority pointer; a requester not valid is never granted.
REQ-020 SHALL, on handshake, drive unit_valid=1 and unit_a/unit_b = granted operands in the same cycle (zero-cycle issue), and advance the pointer to the granted index.
REQ-021 SHALL keep unit_a/unit_b at W'0 when unit_valid=0.
REQ-022 SHALL carry {valid, requester index} through a LAT-deep tag shift register advanced every cycle; the unit is non-stalling.
REQ-023 SHALL assert rsp_valid[tag index] and drive rsp_data=unit_result when the tag register output is valid; otherwise rsp_valid=0 and rsp_data=W'0.
REQ-024 SHALL not backpressure responses; requesters accept rsp_valid unconditionally.
REQ-025 SHALL maintain an in-flight counter of width clog2(LAT+1): +1 on issue, -1 on response, unchanged when both occur in one cycle.
REQ-026 SHALL implement FSM RUN -> DRAINING when drain=1; DRAINING -> DRAINED when in-flight=0 and no issue this cycle; DRAINED -> RUN when drain=0; DRAINING -> RUN if drain deasserts first.
REQ-027 SHALL force req_ready=0 in DRAINING and DRAINED; already-issued ops still complete and respond.
REQ-028 SHALL assert idle only in DRAINED.
REQ-029 SHALL pass float bit patterns (NaN, Inf, denormal, zero) unmodified; the block does not interpret them.

Reset
REQ-030 SHALL, while resetn=0 at a clock edge, clear the tag pipeline and in-flight counter, set the pointer so that requester 0 has top priority, and enter RUN.
REQ-031 SHALL drive req_ready=0, unit_valid=0, rsp_valid=0 and idle=0 during any cycle resetn=0; results of operations in flight at reset are discarded and rsp_valid never asserts for them.

Structure
REQ-032 SHALL place the tag struct {valid, index} type and the pointer-advance helper function in the shared float package, next to the existing float helpers.
REQ-033 SHALL instantiate one sub-module, rr_arbiter (NUM_REQ request vector, pointer in, one-hot grant out, combinational); the tag pipeline, counter and FSM live in float_unit_arbiter.

Verification
REQ-034 SHALL test that all 4 req_valid held high for 8 cycles gives grants 0,1,2,3,0,1,2,3, and each rsp_valid arrives LAT=3 cycles after its grant with its own operands' result.
REQ-035 SHALL test that only req 2 valid for 5 cycles gives 5 back-to-back grants to 2 and 5 consecutive rsp_valid[2].
REQ-036 SHALL test that drain=1 after 3 issues gives req_ready=0 immediately, 3 responses still delivered, and idle=1 on the cycle after the last response; drain=0 then resumes granting from pointer+1.
REQ-037 SHALL test that resetn=0 with 2 ops in flight gives no rsp_valid for those ops, and the next grant goes to requester 0.
REQ-038 SHALL test that operands NaN (exp all ones, frac all ones) and -0 pass to unit_a/unit_b bit-exact.
REQ-039 SHALL test that issue and response in the same cycle with in-flight at LAT leave the counter unchanged and raise no overflow.

Source files
------------

// File: rtl/float_unit_arbiter_pkg.sv
// Shared float package: raw binary32 pattern helpers plus the arbiter's tag,
// state and round-robin pointer types used by float_unit_arbiter.
package float_unit_arbiter_pkg;

  localparam int IDX_W = 4;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } tag_t;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_DRAINING = 2'd1,
    ST_DRAINED  = 2'd2
  } arb_state_t;

  function automatic logic f32_is_nan(input logic [31:0] f);
    return (&f[30:23]) && (|f[22:0]);
  endfunction

  function automatic logic f32_is_zero(input logic [31:0] f);
    return ~|f[30:0];
  endfunction

  // Index following `last` among n requesters, wrapping to 0.
  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] last, input int n);
    if (int'(last) + 1 >= n) return '0;
    return last + 1'b1;
  endfunction

endpackage

// File: rtl/float_unit_arbiter_rr.sv
// Combinational round-robin arbiter: one-hot grant to the first requester
// found when searching upward from the index after `last`.
module rr_arbiter
  import float_unit_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] grant
);

  logic [IDX_W-1:0]   start;
  logic [NUM_REQ-1:0] rot;
  logic [NUM_REQ-1:0] pick;

  // Rotate so the search start sits at bit 0, take the lowest set bit, rotate back.
  always_comb begin
    start = rr_next(last, NUM_REQ);
    rot   = NUM_REQ'({req, req} >> start);
    pick  = rot & (~rot + 1'b1);
    grant = NUM_REQ'(({pick, pick} << start) >> NUM_REQ);
  end

endmodule

// File: rtl/float_unit_arbiter.sv
// Round-robin front end sharing one fixed-latency, non-stalling float unit
// between NUM_REQ requesters, with a drain handshake.
//   state       | meaning
//   ST_RUN      | granting requests
//   ST_DRAINING | issue blocked, waiting for in-flight ops to respond
//   ST_DRAINED  | nothing in flight, idle asserted
module float_unit_arbiter
  import float_unit_arbiter_pkg::*;
#(
  parameter int EXP     = 8,
  parameter int FRAC    = 23,
  parameter int NUM_REQ = 4,
  parameter int LAT     = 3
) (
  input  logic                              clock,
  input  logic                              resetn,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ*(1+EXP+FRAC)-1:0]   req_a,
  input  logic [NUM_REQ*(1+EXP+FRAC)-1:0]   req_b,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic                              unit_valid,
  output logic [EXP+FRAC:0]                 unit_a,
  output logic [EXP+FRAC:0]                 unit_b,
  input  logic [EXP+FRAC:0]                 unit_result,
  output logic [NUM_REQ-1:0]                rsp_valid,
  output logic [EXP+FRAC:0]                 rsp_data,
  input  logic                              drain,
  output logic                              idle
);

  localparam int W  = 1 + EXP + FRAC;
  localparam int CW = $clog2(LAT + 1);

  arb_state_t         state_q, state_d;
  tag_t               tag_q [LAT];
  tag_t               tag_out;
  logic [CW-1:0]      inflight_q, inflight_d;
  logic [IDX_W-1:0]   last_q, gnt_idx;
  logic [NUM_REQ-1:0] grant;
  logic               can_issue, issue, retire;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req   (req_valid),
    .last  (last_q),
    .grant (grant)
  );

  // drain blocks issue in the very cycle it rises, not one cycle later.
  assign can_issue  = resetn && (state_q == ST_RUN) && !drain;
  assign req_ready  = can_issue ? grant : '0;
  assign issue      = |req_ready;
  assign unit_valid = issue;
  assign tag_out    = tag_q[LAT-1];
  assign retire     = tag_out.valid;
  assign idle       = resetn && (state_q == ST_DRAINED);

  always_comb begin
    gnt_idx = '0;
    unit_a  = '0;
    unit_b  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        gnt_idx = IDX_W'(i);
        unit_a  = req_a[i*W +: W];
        unit_b  = req_b[i*W +: W];
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    if (resetn && retire) begin
      rsp_data = unit_result;
      for (int i = 0; i < NUM_REQ; i++) begin
        rsp_valid[i] = (tag_out.idx == IDX_W'(i));
      end
    end
  end

  always_comb begin
    inflight_d = inflight_q;
    if (issue && !retire) begin
      inflight_d = inflight_q + 1'b1;
    end else if (!issue && retire) begin
      inflight_d = inflight_q - 1'b1;
    end
  end

  // Leave DRAINING on the post-update count so idle rises right after the last response.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:      if (drain) state_d = ST_DRAINING;
      ST_DRAINING: begin
        if (!drain) begin
          state_d = ST_RUN;
        end else if ((inflight_d == '0) && !issue) begin
          state_d = ST_DRAINED;
        end
      end
      ST_DRAINED:  if (!drain) state_d = ST_RUN;
      default:     state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q    <= ST_RUN;
      inflight_q <= '0;
      last_q     <= IDX_W'(NUM_REQ - 1);
      for (int i = 0; i < LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      if (issue) begin
        last_q <= gnt_idx;
      end
      tag_q[0] <= '{valid: issue, idx: gnt_idx};
      for (int i = 1; i < LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

endmodule
